// File: rtl/if_pkg.sv
// Shared constants and types for the instruction-fetch unit: reset PC,
// fetch-buffer depth, FSM state encoding and the buffer entry layout.
package if_pkg;

    localparam logic [31:0] IF_RESET_PC   = 32'h0000_0000;
    localparam int          IF_FIFO_DEPTH = 2;

    typedef enum logic {
        RUN  = 1'b0,
        DROP = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory read channel between the fetch unit (master) and the
// instruction memory (slave); read data is valid in the cycle of the ack.
interface if_fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/if_fetch_fifo.sv
// Fetch buffer: small {instr, pc} FIFO with a flush that empties it in one
// cycle; also reports whether it will be full after the current edge.
module if_fetch_fifo
    import if_pkg::*;
#(
    parameter int DEPTH = IF_FIFO_DEPTH
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t wdata,
    input  logic         pop,
    output fetch_entry_t head,
    output logic         not_empty,
    output logic         full_next
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    fetch_entry_t     store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    logic [LVL_W-1:0] level_d;
    logic             do_push;
    logic             do_pop;

    assign not_empty = (level != '0);
    assign do_pop    = pop && not_empty && !flush;
    // A full buffer may still take a push when the head leaves on the same edge.
    assign do_push   = push && !flush && ((level != FULL_LVL) || do_pop);
    assign head      = store[rd_ptr];
    assign full_next = (level_d == FULL_LVL);

    // NOTE: every always_comb output gets a default first so no path can leave it unassigned (no latch).
    always_comb begin
        level_d = level;
        if (flush) begin
            level_d = '0;
        end else if (do_push && !do_pop) begin
            level_d = level + LVL_W'(1);
        end else if (do_pop && !do_push) begin
            level_d = level - LVL_W'(1);
        end
    end

    // NOTE: the data array is deliberately not reset; it is only observed while not_empty.
    always_ff @(posedge clock) begin
        if (do_push) begin
            store[wr_ptr] <= wdata;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            level <= level_d;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: issues one outstanding imem read at a time, buffers
// returned words for IF/ID, and handles redirects (dropping a stale in-flight read).
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = IF_RESET_PC,
    parameter int          FIFO_DEPTH = IF_FIFO_DEPTH
) (
    input  logic            clock,
    input  logic            reset,
    if_fetch_unit_if.master imem,
    input  logic            stall,
    input  logic            redirect,
    input  logic [31:0]     redirect_pc,
    output logic            if_valid,
    output logic [31:0]     IF_IN,
    output logic [31:0]     IF_PC,
    output logic [31:0]     IF_PCplus4
);

    fetch_state_e state_q;
    fetch_state_e state_d;
    logic [31:0]  pc_q;
    logic [31:0]  pc_d;
    logic [31:0]  addr_q;
    logic [31:0]  addr_d;
    logic         req_q;
    logic         req_d;
    logic [31:0]  target;
    logic [31:0]  hold_pc_q;
    logic [31:0]  hold_pc4_q;
    logic [31:0]  head_pc4;
    logic         accepted;
    logic         push;
    logic         pop;
    logic         flush;
    logic         not_empty;
    logic         full_next;
    fetch_entry_t head;
    fetch_entry_t wr_entry;

    assign target   = align_word(redirect_pc);
    assign accepted = req_q && imem.imem_ack;
    assign flush    = redirect;
    assign push     = (state_q == RUN) && accepted && !redirect;
    assign pop      = !stall && !redirect;
    assign wr_entry = '{instr: imem.imem_rdata, pc: addr_q};

    if_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .push      (push),
        .wdata     (wr_entry),
        .pop       (pop),
        .head      (head),
        .not_empty (not_empty),
        .full_next (full_next)
    );

    // pc_q is the address of the outstanding request, or of the next one to issue.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req_d   = req_q;
        addr_d  = addr_q;
        unique case (state_q)
            RUN: begin
                if (redirect) begin
                    pc_d = target;
                    if (req_q && !imem.imem_ack) begin
                        state_d = DROP;
                    end else begin
                        req_d  = 1'b1;
                        addr_d = target;
                    end
                end else if (!req_q || accepted) begin
                    if (accepted) pc_d = pc_q + 32'd4;
                    req_d = !full_next;
                    if (!full_next) addr_d = pc_d;
                end
            end
            DROP: begin
                // The stale request stays on the bus until acked; its data is never pushed.
                if (redirect) pc_d = target;
                if (imem.imem_ack) begin
                    state_d = RUN;
                    req_d   = 1'b1;
                    addr_d  = pc_d;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= '0;
            hold_pc_q  <= '0;
            hold_pc4_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            if (not_empty) begin
                hold_pc_q  <= head.pc;
                hold_pc4_q <= head_pc4;
            end
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;

    assign head_pc4   = head.pc + 32'd4;
    assign if_valid   = not_empty;
    assign IF_IN      = not_empty ? head.instr : '0;
    assign IF_PC      = not_empty ? head.pc : hold_pc_q;
    assign IF_PCplus4 = not_empty ? head_pc4 : hold_pc4_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus random stall/ack/redirect
// traffic, scored against an in-order instruction-stream model.
module tb_if_fetch_unit;
    import if_pkg::*;

    localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFF8;
    localparam int          ACK_NONE = 0;
    localparam int          ACK_REQ  = 1;
    localparam int          ACK_RAW  = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;

    logic        if_valid0, if_valid1;
    logic [31:0] if_in0, if_pc0, if_pc40;
    logic [31:0] if_in1, if_pc1, if_pc41;

    if_fetch_unit_if bus0 ();
    if_fetch_unit_if bus1 ();

    always #5 clock = ~clock;

    if_fetch_unit dut (
        .clock       (clock),
        .reset       (reset),
        .imem        (bus0),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid0),
        .IF_IN       (if_in0),
        .IF_PC       (if_pc0),
        .IF_PCplus4  (if_pc40)
    );

    if_fetch_unit #(
        .RESET_PC (WRAP_PC)
    ) dut_wrap (
        .clock       (clock),
        .reset       (reset),
        .imem        (bus1),
        .stall       (1'b0),
        .redirect    (1'b0),
        .redirect_pc (32'h0),
        .if_valid    (if_valid1),
        .IF_IN       (if_in1),
        .IF_PC       (if_pc1),
        .IF_PCplus4  (if_pc41)
    );

    int          checks   = 0;
    int          failures = 0;

    // Stream model: next instruction address the consumer must see, plus the
    // last head address shown while valid (held when the buffer is empty).
    logic [31:0] exp_pc   = IF_RESET_PC;
    logic [31:0] hold_pc  = '0;
    logic [31:0] hold_pc4 = '0;
    logic        prev_req = 1'b0;
    logic [31:0] prev_addr = '0;
    int          idle     = 0;
    logic        stuck    = 1'b0;
    logic [31:0] exp_pc1  = WRAP_PC;
    logic [31:0] wrap_seen [3] = '{default: '0};
    int          wrap_cnt = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock cycle: score the outputs at the falling edge, then drive inputs.
    task automatic cycle(input logic st, input logic rd, input logic [31:0] rpc, input int ack_mode);
        @(negedge clock);
        if (prev_req) begin
            check("req_hold", 32'(bus0.imem_req), 32'd1);
            check("addr_hold", bus0.imem_addr, prev_addr);
        end
        if (bus0.imem_req) check("addr_align", 32'(bus0.imem_addr[1:0]), 32'd0);
        if (if_valid0) begin
            check("if_pc", if_pc0, exp_pc);
            check("if_pc4", if_pc40, exp_pc + 32'd4);
            check("if_in", if_in0, mem_word(exp_pc));
            hold_pc  = exp_pc;
            hold_pc4 = exp_pc + 32'd4;
        end else begin
            check("if_in_idle", if_in0, 32'd0);
            check("if_pc_idle", if_pc0, hold_pc);
            check("if_pc4_idle", if_pc40, hold_pc4);
        end
        if (if_valid0 && !st && !rd) begin
            exp_pc = exp_pc + 32'd4;
            idle   = 0;
        end else begin
            idle++;
            if (idle > 200) stuck = 1'b1;
        end
        if (rd) exp_pc = rpc & ~32'd3;

        if (if_valid1) begin
            check("wrap_pc", if_pc1, exp_pc1);
            check("wrap_in", if_in1, mem_word(exp_pc1));
            if (wrap_cnt < 3) begin
                wrap_seen[wrap_cnt] = if_pc1;
                wrap_cnt++;
            end
            exp_pc1 = exp_pc1 + 32'd4;
        end

        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        case (ack_mode)
            ACK_REQ: bus0.imem_ack = bus0.imem_req;
            ACK_RAW: bus0.imem_ack = 1'b1;
            default: bus0.imem_ack = 1'b0;
        endcase
        bus0.imem_rdata = bus0.imem_ack ? mem_word(bus0.imem_addr) : $urandom;
        prev_req  = bus0.imem_req && !bus0.imem_ack;
        prev_addr = bus0.imem_addr;
        bus1.imem_ack   = bus1.imem_req;
        bus1.imem_rdata = mem_word(bus1.imem_addr);
    endtask

    // Asserts reset asynchronously, checks outputs cleared at once, releases at a falling edge.
    task automatic apply_reset(input logic late_ack);
        bus0.imem_ack = 1'b0;
        bus1.imem_ack = 1'b0;
        stall    = 1'b0;
        redirect = 1'b0;
        reset    = 1'b0;
        #1;
        check("rst_req", 32'(bus0.imem_req), 32'd0);
        check("rst_addr", bus0.imem_addr, 32'd0);
        check("rst_valid", 32'(if_valid0), 32'd0);
        check("rst_in", if_in0, 32'd0);
        check("rst_pc", if_pc0, 32'd0);
        check("rst_pc4", if_pc40, 32'd0);
        repeat (2) @(negedge clock);
        bus0.imem_ack   = late_ack;
        bus0.imem_rdata = 32'hDEAD_BEEF;
        reset    = 1'b1;
        exp_pc   = IF_RESET_PC;
        exp_pc1  = WRAP_PC;
        hold_pc  = '0;
        hold_pc4 = '0;
        prev_req = 1'b0;
        idle     = 0;
    endtask

    task automatic wait_req(input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clock);
            #1;
            if (bus0.imem_req) found = 1'b1;
            else cycle(1'b0, 1'b0, 32'h0, ACK_REQ);
        end
        check(tag, 32'(found), 32'd1);
    endtask

    initial begin
        logic found;
        bus0.imem_ack = 1'b0;
        bus0.imem_rdata = '0;
        bus1.imem_ack = 1'b0;
        bus1.imem_rdata = '0;
        #1;
        apply_reset(1'b0);

        // Reset release and streaming with ack every cycle.
        cycle(1'b0, 1'b0, 32'h0, ACK_REQ);
        check("first_req", 32'(bus0.imem_req), 32'd1);
        check("first_addr", bus0.imem_addr, IF_RESET_PC);
        check("first_valid_low", 32'(if_valid0), 32'd0);
        cycle(1'b0, 1'b0, 32'h0, ACK_REQ);
        check("first_valid", 32'(if_valid0), 32'd1);
        check("first_pc", if_pc0, 32'd0);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b0, 32'h0, ACK_REQ);
            check("stream_valid", 32'(if_valid0), 32'd1);
        end

        // Stall for 5 cycles: buffer fills, requests stop, head held.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 32'h0, ACK_REQ);
        check("stall_req_low", 32'(bus0.imem_req), 32'd0);
        check("stall_valid", 32'(if_valid0), 32'd1);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b0, 32'h0, ACK_REQ);
            check("release_valid", 32'(if_valid0), 32'd1);
        end

        // Redirect while the request to 0x10 is outstanding; ack 3 cycles later.
        cycle(1'b0, 1'b1, 32'h0, ACK_REQ);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clock);
            #1;
            if (bus0.imem_req && bus0.imem_addr == 32'h10) found = 1'b1;
            else cycle(1'b0, 1'b0, 32'h0, ACK_REQ);
        end
        check("drop_found", 32'(found), 32'd1);
        cycle(1'b0, 1'b1, 32'h0000_0103, ACK_NONE);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 1'b0, 32'h0, ACK_NONE);
            check("drop_req", 32'(bus0.imem_req), 32'd1);
            check("drop_addr", bus0.imem_addr, 32'h10);
            check("drop_valid", 32'(if_valid0), 32'd0);
        end
        cycle(1'b0, 1'b0, 32'h0, ACK_REQ);
        cycle(1'b0, 1'b0, 32'h0, ACK_NONE);
        check("after_drop_req", 32'(bus0.imem_req), 32'd1);
        check("after_drop_addr", bus0.imem_addr, 32'h100);
        check("after_drop_valid", 32'(if_valid0), 32'd0);
        cycle(1'b0, 1'b0, 32'h0, ACK_REQ);
        cycle(1'b0, 1'b0, 32'h0, ACK_REQ);
        check("redir_valid", 32'(if_valid0), 32'd1);
        check("redir_pc", if_pc0, 32'h100);

        // Redirect in the same cycle as the ack: data dropped, no DROP state.
        wait_req("same_ack_found");
        cycle(1'b0, 1'b1, 32'h0000_0200, ACK_REQ);
        cycle(1'b0, 1'b0, 32'h0, ACK_NONE);
        check("same_ack_req", 32'(bus0.imem_req), 32'd1);
        check("same_ack_addr", bus0.imem_addr, 32'h200);
        check("same_ack_valid", 32'(if_valid0), 32'd0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 32'h0, ACK_REQ);

        // Reset in the middle of a request, with a late ack right after release.
        wait_req("mid_req_found");
        apply_reset(1'b1);
        cycle(1'b0, 1'b0, 32'h0, ACK_REQ);
        check("restart_req", 32'(bus0.imem_req), 32'd1);
        check("restart_addr", bus0.imem_addr, IF_RESET_PC);
        cycle(1'b0, 1'b0, 32'h0, ACK_REQ);
        check("restart_valid", 32'(if_valid0), 32'd1);
        check("restart_pc", if_pc0, IF_RESET_PC);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 4, $urandom,
                  ($urandom_range(0, 99) < 60) ? ACK_REQ : ACK_NONE);
        end
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 32'h0, ACK_REQ);

        check("progress", 32'(stuck), 32'd0);
        check("wrap_count", 32'(wrap_cnt >= 3), 32'd1);
        check("wrap_seq0", wrap_seen[0], 32'hFFFF_FFF8);
        check("wrap_seq1", wrap_seen[1], 32'hFFFF_FFFC);
        check("wrap_seq2", wrap_seen[2], 32'h0000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
